// File: rtl/and_16x1.sv
`default_nettype none
// ============================================================================
// Module      : and_16x1
// Description : AND reduction of two WIDTH-bit operands. y is 1 only when every
//               bit of a and every bit of b is 1.
//               Combinational outputs : y, and_vec (= a & b)
//               Registered outputs    : y_q, out_valid, PIPE_STAGES cycles
//                                       after an in_valid capture
//               Ports : clk, rst (sync, active-high), a, b, in_valid,
//                       y, and_vec, y_q, out_valid
// Revision    : 1.0 - initial release
// ============================================================================
module and_16x1 #(
    parameter int WIDTH       = 8,
    parameter int PIPE_STAGES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic             y,
    output logic [WIDTH-1:0] and_vec,
    output logic             y_q,
    output logic             out_valid
);

    // The per-bit a & b forms the first tree level. The remaining levels reduce
    // and_vec as a heap-indexed binary tree: node k has children 2k and 2k+1,
    // the leaves sit at c_LEAVES..2*c_LEAVES-1, and the root is node 1.
    localparam int c_LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 0;
    localparam int c_LEAVES = 1 << c_LEVELS;

    logic [2*c_LEAVES-1:1] w_node;

    assign and_vec = a & b;

    // Leaves beyond WIDTH are tied to 1, the AND identity, so an odd operand
    // is effectively passed up the tree unchanged.
    generate
        for (genvar i = 0; i < c_LEAVES; i++) begin : g_leaf
            if (i < WIDTH) begin : g_real
                assign w_node[c_LEAVES+i] = and_vec[i];
            end else begin : g_pad
                assign w_node[c_LEAVES+i] = 1'b1;
            end
        end

        for (genvar k = 1; k < c_LEAVES; k++) begin : g_node
            assign w_node[k] = w_node[2*k] & w_node[2*k+1];
        end
    endgenerate

    assign y = w_node[1];

    // Registered path: shift of (valid, result) pairs. The result bit is
    // forced to 0 for bubbles so y_q is 0 whenever out_valid is 0.
    logic [PIPE_STAGES-1:0] r_valid;
    logic [PIPE_STAGES-1:0] r_res;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_res   <= '0;
        end else begin
            r_valid[0] <= in_valid;
            r_res[0]   <= in_valid & y;
            for (int s = 1; s < PIPE_STAGES; s++) begin
                r_valid[s] <= r_valid[s-1];
                r_res[s]   <= r_res[s-1];
            end
        end
    end

    assign out_valid = r_valid[PIPE_STAGES-1];
    assign y_q       = r_res[PIPE_STAGES-1];

endmodule
`default_nettype wire

// File: tb/tb_and_16x1.sv
`default_nettype none
// ============================================================================
// Module      : tb_and_16x1
// Description : Self-checking bench for and_16x1. Three instances with
//               PIPE_STAGES = 1, 3 and 4 share one stimulus stream. Expected
//               registered outputs come from a per-edge history of captures
//               and resets; a capture emerges D edges later unless any reset
//               edge occurred in between.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_and_16x1;

    logic       clk;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic       in_valid;

    logic       y1, y3, y4;
    logic [7:0] v1, v3, v4;
    logic       yq1, yq3, yq4;
    logic       ov1, ov3, ov4;

    int n_checks = 0;
    int n_errors = 0;

    // Per-edge history: capture request, golden result, reset.
    bit rec_v[$];
    bit rec_y[$];
    bit rec_r[$];

    and_16x1 #(.WIDTH(8), .PIPE_STAGES(1)) u_dut1 (
        .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid),
        .y(y1), .and_vec(v1), .y_q(yq1), .out_valid(ov1)
    );

    and_16x1 #(.WIDTH(8), .PIPE_STAGES(3)) u_dut3 (
        .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid),
        .y(y3), .and_vec(v3), .y_q(yq3), .out_valid(ov3)
    );

    and_16x1 #(.WIDTH(8), .PIPE_STAGES(4)) u_dut4 (
        .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid),
        .y(y4), .and_vec(v4), .y_q(yq4), .out_valid(ov4)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Expected {out_valid, y_q} after the latest edge for a pipeline of depth d.
    function automatic logic [1:0] model_out(input int d);
        int  n;
        int  e;
        bit  v;
        n = rec_v.size() - 1;
        e = n - d + 1;
        if (e < 0) return 2'b00;
        v = rec_v[e];
        for (int k = e; k <= n; k++) begin
            if (rec_r[k]) v = 1'b0;
        end
        return {v, v & rec_y[e]};
    endfunction

    // One clock: drive inputs while clk is low, check the combinational
    // outputs after settling, then check the registered outputs after the edge.
    task automatic step(input logic r, input logic iv, input logic [7:0] av, input logic [7:0] bv);
        logic       exp_y;
        logic [1:0] m;
        @(negedge clk);
        rst      = r;
        in_valid = iv;
        a        = av;
        b        = bv;
        exp_y    = (av == 8'hFF) && (bv == 8'hFF);
        #5;
        check("y", {31'd0, y1}, {31'd0, exp_y});
        check("and_vec", {24'd0, v1}, {24'd0, av & bv});
        check("y_d3", {31'd0, y3}, {31'd0, exp_y});
        check("and_vec_d4", {24'd0, v4}, {24'd0, av & bv});
        @(posedge clk);
        rec_v.push_back(iv);
        rec_y.push_back(exp_y);
        rec_r.push_back(r);
        #1;
        m = model_out(1);
        check("out_valid_p1", {31'd0, ov1}, {31'd0, m[1]});
        check("y_q_p1", {31'd0, yq1}, {31'd0, m[0]});
        m = model_out(3);
        check("out_valid_p3", {31'd0, ov3}, {31'd0, m[1]});
        check("y_q_p3", {31'd0, yq3}, {31'd0, m[0]});
        m = model_out(4);
        check("out_valid_p4", {31'd0, ov4}, {31'd0, m[1]});
        check("y_q_p4", {31'd0, yq4}, {31'd0, m[0]});
    endtask

    initial begin
        logic [15:0] w;
        logic [7:0]  ra;
        logic [7:0]  rb;
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;

        // Reset for two cycles; in_valid high shows reset wins over capture.
        step(1'b1, 1'b1, 8'hFF, 8'hFF);
        step(1'b1, 1'b1, 8'hFF, 8'hFF);

        // Directed combinational vectors, also captured into the pipelines.
        step(1'b0, 1'b1, 8'hFF, 8'hFF);
        step(1'b0, 1'b1, 8'h00, 8'h00);
        step(1'b0, 1'b1, 8'h0A, 8'h0A);
        step(1'b0, 1'b1, 8'h72, 8'h5B);
        step(1'b0, 1'b1, 8'hFF, 8'h3B);

        // Single-zero sweep across all 16 input bits, then all ones.
        for (int i = 0; i < 16; i++) begin
            w = 16'hFFFF;
            w[i] = 1'b0;
            step(1'b0, 1'b1, w[15:8], w[7:0]);
        end
        step(1'b0, 1'b1, 8'hFF, 8'hFF);

        // Pipeline sequence and bubble pattern.
        step(1'b0, 1'b1, 8'hFF, 8'hFF);
        step(1'b0, 1'b1, 8'hFF, 8'hFE);
        step(1'b0, 1'b1, 8'hFF, 8'hFF);
        step(1'b0, 1'b1, 8'hFF, 8'hFF);
        step(1'b0, 1'b0, 8'hFF, 8'hFF);
        step(1'b0, 1'b1, 8'hFF, 8'hFF);

        // Mid-stream reset with results in flight, then idle to expose stale data.
        step(1'b0, 1'b1, 8'hFF, 8'hFF);
        step(1'b0, 1'b1, 8'hFF, 8'hFF);
        step(1'b1, 1'b1, 8'hFF, 8'hFF);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'hFF, 8'hFF);

        // Eight back-to-back random pairs, biased toward all-ones operands.
        for (int i = 0; i < 8; i++) begin
            ra = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
            rb = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
            step(1'b0, 1'b1, ra, rb);
        end
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00, 8'h00);

        // Random traffic with occasional resets and bubbles.
        for (int i = 0; i < 300; i++) begin
            ra = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
            rb = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
            step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), ra, rb);
        end
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
